// File: rtl/issue_arbiter.sv
// Sole write port of the command scheduler's issue FIFO: picks one ready command per cycle
// from NUM_REQ requesters with round-robin fairness, FIFO-flag throttling, aging and a flush handshake.
module issue_arbiter #(
    parameter int NUM_REQ      = 8,
    parameter int CMD_W        = 21,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ-1:0]       req_urgent_i,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     fifo_wen_o,
    output logic [CMD_W-1:0]         fifo_data_o,
    input  logic                     fifo_full_i,
    input  logic                     fifo_virtual_full_i,
    input  logic                     fifo_empty_i,
    input  logic                     flush_req_i,
    output logic                     flush_done_o,
    output logic [1:0]               mode_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int AGE_W = 8;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'd0,
        MODE_THROTTLE = 2'd1,
        MODE_STALL    = 2'd2,
        MODE_FLUSH    = 2'd3
    } mode_e;

    mode_e              state_q, state_d, flag_state;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AGE_W-1:0]   age_q [NUM_REQ];
    logic [AGE_W-1:0]   age_d [NUM_REQ];
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               fifo_wen_q, fifo_wen_d;
    logic [CMD_W-1:0]   fifo_data_q, fifo_data_d;
    logic               flush_done_q, flush_done_d;

    logic [NUM_REQ-1:0] eligible, urgent_eff, cand;
    logic               sel_valid;
    logic [PTR_W-1:0]   sel_idx;
    logic [CMD_W-1:0]   sel_cmd;

    // NOTE: combinational blocks assign every output a default first so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        if (fifo_full_i)              flag_state = MODE_STALL;
        else if (fifo_virtual_full_i) flag_state = MODE_THROTTLE;
        else                          flag_state = MODE_NORMAL;

        // flush_done_q high means we just left FLUSH; a still-asserted flush_req is stale.
        if (flush_req_i && state_q != MODE_FLUSH && !flush_done_q) begin
            state_d = MODE_FLUSH;
        end else if (state_q == MODE_FLUSH) begin
            if (fifo_empty_i && !fifo_wen_q) begin
                flush_done_d = 1'b1;
                state_d      = flag_state;
            end
        end else begin
            state_d = flag_state;
        end
    end

    always_comb begin
        eligible = req_i & ~grant_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            urgent_eff[i] = req_urgent_i[i] | (age_q[i] == AGE_MAX);
        end
        unique case (state_d)
            MODE_NORMAL:   cand = (|(eligible & urgent_eff)) ? (eligible & urgent_eff) : eligible;
            MODE_THROTTLE: cand = eligible & urgent_eff;
            default:       cand = '0;
        endcase
    end

    // Round-robin search from rr_ptr upward with wrap.
    always_comb begin
        int idx;
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_cmd   = '0;
        idx       = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = int'(rr_ptr_q) + j;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!sel_valid && cand[idx]) begin
                sel_valid = 1'b1;
                sel_idx   = PTR_W'(idx);
                sel_cmd   = req_cmd_i[idx*CMD_W +: CMD_W];
            end
        end
    end

    always_comb begin
        grant_d     = sel_valid ? (NUM_REQ'(1) << sel_idx) : '0;
        fifo_wen_d  = sel_valid;
        fifo_data_d = sel_valid ? sel_cmd : fifo_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (sel_valid) begin
            rr_ptr_d = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            age_d[i] = age_q[i];
            if (!req_i[i] || grant_d[i])           age_d[i] = '0;
            else if (eligible[i] && age_q[i] != AGE_MAX) age_d[i] = age_q[i] + AGE_W'(1);
        end
    end

    // NOTE: the age array is a handful of flops, not a RAM, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= MODE_NORMAL;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            fifo_wen_q   <= 1'b0;
            fifo_data_q  <= '0;
            flush_done_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) age_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            fifo_wen_q   <= fifo_wen_d;
            fifo_data_q  <= fifo_data_d;
            flush_done_q <= flush_done_d;
            for (int i = 0; i < NUM_REQ; i++) age_q[i] <= age_d[i];
        end
    end

    assign grant_o      = grant_q;
    assign fifo_wen_o   = fifo_wen_q;
    assign fifo_data_o  = fifo_data_q;
    assign flush_done_o = flush_done_q;
    assign mode_o       = state_q;

endmodule

// File: doc/issue_arbiter.md
# issue_arbiter

Multi-requester arbiter that sits in front of the command scheduler's issue FIFO and is its sole write port. It selects one ready command per cycle from NUM_REQ bank-level requesters and writes it into the FIFO. It throttles on the FIFO's virtual_full and full flags, prevents starvation with per-requester age counters, and provides a flush handshake that drains the FIFO before mode changes such as refresh entry.

## Interface
- NUM_REQ, 8: number of requesters (2..16)
- CMD_W, 21: issue command width, {command[20:17], addr[16:3], bank[2:0]}
- STARVE_LIMIT, 15: wait cycles after which a pending request is promoted to urgent (1..255)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  request valid per requester
- req_urgent  in  NUM_REQ  request is high-priority (refresh/forced precharge)
- req_cmd  in  NUM_REQ*CMD_W  command per requester, slice i = bits [i*CMD_W +: CMD_W]
- grant  out  NUM_REQ  one-hot, one-cycle pulse, registered
- fifo_wen  out  1  issue FIFO write enable, registered
- fifo_data  out  CMD_W  issue FIFO write data, registered
- fifo_full  in  1  FIFO full flag
- fifo_virtual_full  in  1  FIFO almost-full flag
- fifo_empty  in  1  FIFO empty flag
- flush_req  in  1  level; request drain of the FIFO
- flush_done  out  1  one-cycle pulse when drained
- mode  out  2  current state: 0 NORMAL, 1 THROTTLE, 2 STALL, 3 FLUSH

## Operation
- Reset values: grant=0, fifo_wen=0, fifo_data=0, flush_done=0, mode=NORMAL, rr_ptr=0, all age counters=0.
- Eligibility in cycle t: req[i]=1 and grant[i]=0. A requester that currently sees its grant cannot be granted again in the same cycle.
- Effective urgent: req_urgent[i] | (age[i]==STARVE_LIMIT).
- FSM, evaluated every cycle, first matching rule wins:
  - flush_req=1 and state≠FLUSH → FLUSH.
  - In FLUSH: no grants. Exit when fifo_empty=1 and fifo_wen=0; at exit, pulse flush_done for 1 cycle and go to the state given by the flags. flush_req is ignored while flush_done is high.
  - Otherwise: fifo_full → STALL; else fifo_virtual_full → THROTTLE; else NORMAL.
- Grants by state (decided on the next-state value):
  - NORMAL: grant one eligible requester, urgent class first.
  - THROTTLE: grant only effective-urgent requesters.
  - STALL and FLUSH: no grants.
- Round-robin order: within the chosen class, pick the first eligible index searching from rr_ptr upward, wrapping at NUM_REQ-1 → 0. On a grant to index k, rr_ptr ← (k+1) mod NUM_REQ. rr_ptr is unchanged when there is no grant.
- Age counters: age[i] increments, saturating at STARVE_LIMIT, when eligible and not selected. It clears to 0 on selection or when req[i]=0.
- Requester contract: hold req and req_cmd stable until grant. In the cycle after grant, either drop req or present the next command.

## Timing
- Selection in cycle t, using req, req_cmd and FIFO flags sampled at t. At edge t+1: grant[k]=1, fifo_wen=1, fifo_data=req_cmd slice k, all for exactly 1 cycle. One write per cycle at most; back-to-back writes are allowed.
- Latency from flag to effect: 1 cycle. The FIFO full threshold (≥4 free slots) absorbs the in-flight write.
- flush_req rising at t: no grant is issued at t+1. A grant issued at t (decided at t-1) still completes.
- Asynchronous reset mid-operation clears all outputs immediately; a write in flight is dropped.

## Test plan
- Single requester 3 asserts req with cmd 0x1A5F3 from reset → grant=0x08, fifo_wen=1, fifo_data=0x1A5F3 one cycle later; rr_ptr=4.
- All 8 requesters hold req continuously in NORMAL, none urgent → grants 0x01,0x02,…,0x80,0x01 on consecutive cycles, with no repeats within 8 grants.
- fifo_virtual_full=1, req=0xFF, req_urgent=0x20 → only grant 0x20. With req_urgent=0, requester 0 is granted after exactly STARVE_LIMIT=15 waiting cycles.
- fifo_full=1 with requests pending → grant=0 and mode=2 every cycle. Deasserting full → grant on the following cycle.
- flush_req raised while the FIFO holds 5 entries → no grants; flush_done pulses exactly 1 cycle after fifo_empty=1; mode returns to 0.
- rst_n pulsed low while grant=0x04 → grant, fifo_wen and mode read 0 immediately; arbitration resumes from index 0.
